// File: rtl/countdown_timer_bcd_if.sv
// Control and display bundle between the lock FSM (master) and the BCD countdown timer (slave).
interface countdown_timer_bcd_if;
  logic        load;
  logic [15:0] load_digits;
  logic        start;
  logic        stop;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        running;
  logic        expired;
  logic        expire_pulse;
  logic        warn;

  modport master (
    output load, load_digits, start, stop,
    input  min_tens, min_ones, sec_tens, sec_ones, running, expired, expire_pulse, warn
  );

  modport slave (
    input  load, load_digits, start, stop,
    output min_tens, min_ones, sec_tens, sec_ones, running, expired, expire_pulse, warn
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer held as four BCD digits with IDLE/RUN/PAUSE/EXPIRED control.
// Optional low-time warning output is built only when TIMER_WARN_EN is defined.
module countdown_timer_bcd #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int WARN_SECS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  countdown_timer_bcd_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int             PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          pulse_q, pulse_d;

  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic       dec_zero;
  logic       count_zero;

  // One-second decrement with the BCD borrow chain; only used while the count is non-zero.
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q - 4'd1;
    if (sec_ones_q == 4'd0) begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q == 4'd0) begin
        dec_sec_tens = 4'd5;
        if (min_ones_q == 4'd0) begin
          dec_min_ones = 4'd9;
          dec_min_tens = min_tens_q - 4'd1;
        end else begin
          dec_min_ones = min_ones_q - 4'd1;
        end
      end else begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end
    end
    dec_zero   = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                 (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);
    count_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                 (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    pulse_d    = 1'b0;

    if (bus.load) begin
      min_tens_d = (bus.load_digits[15:12] > 4'd9) ? 4'd9 : bus.load_digits[15:12];
      min_ones_d = (bus.load_digits[11:8]  > 4'd9) ? 4'd9 : bus.load_digits[11:8];
      sec_tens_d = (bus.load_digits[7:4]   > 4'd5) ? 4'd5 : bus.load_digits[7:4];
      sec_ones_d = (bus.load_digits[3:0]   > 4'd9) ? 4'd9 : bus.load_digits[3:0];
      state_d    = ST_IDLE;
      presc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          // stop wins over a simultaneous start; the prescaler keeps its paused value
          if (bus.start && !bus.stop && !count_zero) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d    = '0;
            min_tens_d = dec_min_tens;
            min_ones_d = dec_min_ones;
            sec_tens_d = dec_sec_tens;
            sec_ones_d = dec_sec_ones;
            if (dec_zero) begin
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_EXPIRED;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.min_tens     = min_tens_q;
  assign bus.min_ones     = min_ones_q;
  assign bus.sec_tens     = sec_tens_q;
  assign bus.sec_ones     = sec_ones_q;
  assign bus.running      = running_q;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = pulse_q;

`ifdef TIMER_WARN_EN
  logic warn_q, warn_d;

  // Evaluated on next-state values so warn changes on the same edge as the digits.
  always_comb begin
    warn_d = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
             (min_tens_d == 4'd0) && (min_ones_d == 4'd0) &&
             ((7'(sec_tens_d) * 7'd10 + 7'(sec_ones_d)) <= 7'(WARN_SECS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign bus.warn = warn_q;
`else
  assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd with TICK_CYCLES=4, WARN_SECS=10.
module tb_countdown_timer_bcd;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  countdown_timer_bcd_if tif ();

  countdown_timer_bcd #(
    .TICK_CYCLES(4),
    .WARN_SECS  (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif.slave)
  );

  logic [15:0] digits;
  assign digits = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    tif.load = 1'b1;
    tif.load_digits = val;
    step();
    tif.load = 1'b0;
  endtask

  task automatic do_start();
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total_cnt++; if (digits !== 16'h0000) $display("FAIL rst_digits: got %h exp 0000", digits); else pass_cnt++;
    total_cnt++; if ({tif.running, tif.expired, tif.expire_pulse, tif.warn} !== 4'b0000)
      $display("FAIL rst_flags: got %b exp 0000", {tif.running, tif.expired, tif.expire_pulse, tif.warn}); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (tif.running !== 1'b0) $display("FAIL rst_idle: running=%b exp 0", tif.running); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_borrow_chain();
    do_load(16'h0102);
    do_start();
    total_cnt++; if (tif.running !== 1'b1) $display("FAIL t1_running: got %b exp 1", tif.running); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (digits !== 16'h0102) $display("FAIL t1_early: got %h exp 0102", digits); else pass_cnt++;
    step();
    total_cnt++; if (digits !== 16'h0101) $display("FAIL t1_0101: got %h exp 0101", digits); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if (digits !== 16'h0100) $display("FAIL t1_0100: got %h exp 0100", digits); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if (digits !== 16'h0059) $display("FAIL t1_0059: got %h exp 0059", digits); else pass_cnt++;
    $display("test_borrow_chain done");
  endtask

  task automatic test_expiry();
    do_load(16'h0002);
    do_start();
    repeat (4) step();
    total_cnt++; if (digits !== 16'h0001) $display("FAIL t2_0001: got %h exp 0001", digits); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if ({tif.expired, tif.expire_pulse} !== 2'b00)
      $display("FAIL t2_pre: expired/pulse=%b exp 00", {tif.expired, tif.expire_pulse}); else pass_cnt++;
    step();
    total_cnt++; if (digits !== 16'h0000) $display("FAIL t2_0000: got %h exp 0000", digits); else pass_cnt++;
    total_cnt++; if ({tif.running, tif.expired, tif.expire_pulse} !== 3'b011)
      $display("FAIL t2_entry: run/exp/pulse=%b exp 011", {tif.running, tif.expired, tif.expire_pulse}); else pass_cnt++;
    step();
    total_cnt++; if ({tif.expired, tif.expire_pulse} !== 2'b10)
      $display("FAIL t2_pulse_once: exp/pulse=%b exp 10", {tif.expired, tif.expire_pulse}); else pass_cnt++;
    do_start();
    repeat (6) step();
    total_cnt++; if ({digits, tif.running, tif.expired} !== {16'h0000, 2'b01})
      $display("FAIL t2_hold: digits=%h run=%b exp=%b exp 0000/0/1", digits, tif.running, tif.expired); else pass_cnt++;
    $display("test_expiry done");
  endtask

  task automatic test_pause_resume();
    do_load(16'h0030);
    do_start();
    repeat (2) step();
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    total_cnt++; if (tif.running !== 1'b0) $display("FAIL t3_paused: running=%b exp 0", tif.running); else pass_cnt++;
    repeat (5) step();
    total_cnt++; if (digits !== 16'h0030) $display("FAIL t3_held: got %h exp 0030", digits); else pass_cnt++;
    do_start();
    total_cnt++; if (tif.running !== 1'b1) $display("FAIL t3_resume: running=%b exp 1", tif.running); else pass_cnt++;
    step();
    total_cnt++; if (digits !== 16'h0030) $display("FAIL t3_not_yet: got %h exp 0030", digits); else pass_cnt++;
    step();
    total_cnt++; if (digits !== 16'h0029) $display("FAIL t3_dec: got %h exp 0029", digits); else pass_cnt++;
    $display("test_pause_resume done");
  endtask

  task automatic test_clamp_and_ignores();
    do_load(16'hAB7C);
    total_cnt++; if (digits !== 16'h9959) $display("FAIL t4_clamp: got %h exp 9959", digits); else pass_cnt++;
    tif.start = 1'b1;
    tif.stop  = 1'b1;
    step();
    tif.start = 1'b0;
    tif.stop  = 1'b0;
    repeat (5) step();
    total_cnt++; if ({digits, tif.running} !== {16'h9959, 1'b0})
      $display("FAIL t4_start_stop: digits=%h run=%b exp 9959/0", digits, tif.running); else pass_cnt++;
    tif.start = 1'b1;
    do_load(16'h0005);
    tif.start = 1'b0;
    total_cnt++; if ({digits, tif.running, tif.warn} !== {16'h0005, 2'b00})
      $display("FAIL t4_load_prio: digits=%h run=%b warn=%b exp 0005/0/0", digits, tif.running, tif.warn); else pass_cnt++;
    do_load(16'h0000);
    do_start();
    total_cnt++; if ({tif.running, tif.expired} !== 2'b00)
      $display("FAIL t4_zero_start: run/exp=%b exp 00", {tif.running, tif.expired}); else pass_cnt++;
    $display("test_clamp_and_ignores done");
  endtask

  task automatic test_async_reset();
    do_load(16'h0007);
    do_start();
    repeat (8) step();
    total_cnt++; if (digits !== 16'h0005) $display("FAIL t5_0005: got %h exp 0005", digits); else pass_cnt++;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({digits, tif.running, tif.expired, tif.expire_pulse, tif.warn} !== 20'h00000)
      $display("FAIL t5_async: digits=%h flags=%b exp 0000/0000", digits,
               {tif.running, tif.expired, tif.expire_pulse, tif.warn}); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (tif.expire_pulse !== 1'b0) $display("FAIL t5_no_pulse: got %b exp 0", tif.expire_pulse); else pass_cnt++;
    rst = 1'b0;
    repeat (6) step();
    total_cnt++; if ({digits, tif.running} !== {16'h0000, 1'b0})
      $display("FAIL t5_idle: digits=%h run=%b exp 0000/0", digits, tif.running); else pass_cnt++;
    $display("test_async_reset done");
  endtask

  task automatic test_warn();
    do_load(16'h0012);
    do_start();
    total_cnt++; if (tif.warn !== 1'b0) $display("FAIL t6_warn_12: got %b exp 0", tif.warn); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if ({digits, tif.warn} !== {16'h0011, 1'b0})
      $display("FAIL t6_warn_11: digits=%h warn=%b exp 0011/0", digits, tif.warn); else pass_cnt++;
    repeat (4) step();
`ifdef TIMER_WARN_EN
    total_cnt++; if ({digits, tif.warn} !== {16'h0010, 1'b1})
      $display("FAIL t6_warn_10: digits=%h warn=%b exp 0010/1", digits, tif.warn); else pass_cnt++;
    repeat (4) step();
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    total_cnt++; if ({digits, tif.running, tif.warn} !== {16'h0009, 2'b01})
      $display("FAIL t6_warn_pause: digits=%h run=%b warn=%b exp 0009/0/1", digits, tif.running, tif.warn); else pass_cnt++;
    do_start();
    repeat (36) step();
    total_cnt++; if ({digits, tif.expired, tif.warn} !== {16'h0000, 2'b10})
      $display("FAIL t6_warn_expired: digits=%h exp=%b warn=%b exp 0000/1/0", digits, tif.expired, tif.warn); else pass_cnt++;
`else
    total_cnt++; if ({digits, tif.warn} !== {16'h0010, 1'b0})
      $display("FAIL t6_warn_off: digits=%h warn=%b exp 0010/0", digits, tif.warn); else pass_cnt++;
`endif
    $display("test_warn done");
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    tif.load        = 1'b0;
    tif.load_digits = 16'h0000;
    tif.start       = 1'b0;
    tif.stop        = 1'b0;
    test_reset();
    test_borrow_chain();
    test_expiry();
    test_pause_resume();
    test_clamp_and_ignores();
    test_async_reset();
    test_warn();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
